// File: rtl/thermal_pkg.sv
// thermal_pkg: channel state encoding and counter sizing shared by the thermal shutdown controller
package thermal_pkg;
  typedef enum logic [2:0] {RUN, ARM, COOL, HOLD, LOCK} th_state_t;
  function automatic int cnt_width(input int debounce, input int cooldown);
    return $clog2((debounce > cooldown ? debounce : cooldown) + 1);
  endfunction
endpackage

// File: rtl/thermal_ch_fsm.sv
// thermal_ch_fsm: one channel of overheat debounce, latched shutdown, cooldown, restart and lockout
module thermal_ch_fsm
  import thermal_pkg::*;
#(
  parameter int DEBOUNCE = 4,
  parameter int COOLDOWN = 16,
  parameter int MAX_TRIPS = 3,
  parameter int AUTO_RESTART = 1,
  parameter int TRIP_W = $clog2(MAX_TRIPS + 1),
  parameter int CNT_W = cnt_width(DEBOUNCE, COOLDOWN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              overheat,
  input  logic              restart_req,
  output logic              shut_off,
  output logic              locked,
  output logic [TRIP_W-1:0] trip_count
);
  th_state_t state, nxt;
  logic [CNT_W-1:0] cnt, nxt_cnt, cnt_inc;
  logic [TRIP_W-1:0] trips_inc;
  logic trip, cool_done;
  assign cnt_inc = cnt + 1'b1;
  assign trips_inc = trip_count + 1'b1;
  assign cool_done = !overheat && cnt_inc == CNT_W'(COOLDOWN);
  assign trip = overheat && ((state == RUN && DEBOUNCE == 1) || (state == ARM && cnt_inc == CNT_W'(DEBOUNCE)));
  always_comb begin
    nxt = state;
    nxt_cnt = cnt;
    case (state)
      RUN: begin
        nxt = overheat ? ARM : RUN;
        nxt_cnt = overheat ? CNT_W'(1) : '0;
      end
      ARM: begin
        nxt = overheat ? ARM : RUN;
        nxt_cnt = overheat ? cnt_inc : '0;
      end
      COOL: begin
        nxt = cool_done ? (AUTO_RESTART != 0 ? RUN : HOLD) : COOL;
        nxt_cnt = (overheat || cool_done) ? '0 : cnt_inc;
      end
      HOLD: begin
        // a restart request while still hot is dropped, not treated as a re-trip
        nxt = restart_req ? (overheat ? HOLD : RUN) : (overheat ? COOL : HOLD);
        nxt_cnt = '0;
      end
      default: nxt = LOCK;
    endcase
    if (trip) begin
      nxt = trips_inc == TRIP_W'(MAX_TRIPS) ? LOCK : COOL;
      nxt_cnt = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt <= '0;
      trip_count <= '0;
      shut_off <= 1'b0;
      locked <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= nxt_cnt;
      if (trip) trip_count <= trips_inc;
      shut_off <= nxt == COOL || nxt == HOLD || nxt == LOCK;
      locked <= nxt == LOCK;
    end
  end
endmodule

// File: rtl/thermal_shutdown_ctrl.sv
// thermal_shutdown_ctrl: multi-channel thermal protection supervisor between temperature
// comparators and power sequencing; one independent thermal_ch_fsm per channel
module thermal_shutdown_ctrl #(
  parameter int NUM_CH = 4,
  parameter int DEBOUNCE = 4,
  parameter int COOLDOWN = 16,
  parameter int MAX_TRIPS = 3,
  parameter int AUTO_RESTART = 1,
  parameter int TRIP_W = $clog2(MAX_TRIPS + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        cpu_overheated,
  input  logic [NUM_CH-1:0]        restart_req,
  output logic [NUM_CH-1:0]        shut_off_computer,
  output logic                     any_shutdown,
  output logic [NUM_CH-1:0]        locked,
  output logic [NUM_CH*TRIP_W-1:0] trip_count
);
  genvar i;
  generate
    for (i = 0; i < NUM_CH; i++) begin : g_ch
      thermal_ch_fsm #(
        .DEBOUNCE(DEBOUNCE),
        .COOLDOWN(COOLDOWN),
        .MAX_TRIPS(MAX_TRIPS),
        .AUTO_RESTART(AUTO_RESTART),
        .TRIP_W(TRIP_W)
      ) u_ch (
        .clk(clk),
        .rst_n(rst_n),
        .overheat(cpu_overheated[i]),
        .restart_req(restart_req[i]),
        .shut_off(shut_off_computer[i]),
        .locked(locked[i]),
        .trip_count(trip_count[i*TRIP_W +: TRIP_W])
      );
    end
  endgenerate
  assign any_shutdown = |shut_off_computer;
endmodule

// File: tb/tb_thermal_shutdown_ctrl.sv
// tb_thermal_shutdown_ctrl: auto-restart and manual-restart instances driven together and
// compared each cycle against a run-length model of the channel rules
module tb_thermal_shutdown_ctrl;
  localparam int N = 4, DEB = 4, CD = 8, MT = 3, TW = $clog2(MT + 1);
  logic clk = 1'b0, rst_n = 1'b1;
  logic [N-1:0] oh = '0, rr = '0;
  logic [N-1:0] shut_a, lock_a, shut_m, lock_m;
  logic any_a, any_m;
  logic [N*TW-1:0] tc_a, tc_m;
  int total = 0, passed = 0;
  bit m_shut[2][N], m_lock[2][N], m_done[2][N];
  int m_hi[2][N], m_lo[2][N], m_trips[2][N];
  always #5 clk = ~clk;
  thermal_shutdown_ctrl #(.NUM_CH(N), .DEBOUNCE(DEB), .COOLDOWN(CD), .MAX_TRIPS(MT), .AUTO_RESTART(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .cpu_overheated(oh), .restart_req(rr),
    .shut_off_computer(shut_a), .any_shutdown(any_a), .locked(lock_a), .trip_count(tc_a));
  thermal_shutdown_ctrl #(.NUM_CH(N), .DEBOUNCE(DEB), .COOLDOWN(CD), .MAX_TRIPS(MT), .AUTO_RESTART(0)) dut_m (
    .clk(clk), .rst_n(rst_n), .cpu_overheated(oh), .restart_req(rr),
    .shut_off_computer(shut_m), .any_shutdown(any_m), .locked(lock_m), .trip_count(tc_m));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic model_reset();
    for (int m = 0; m < 2; m++)
      for (int c = 0; c < N; c++) begin
        m_shut[m][c] = 0; m_lock[m][c] = 0; m_done[m][c] = 0;
        m_hi[m][c] = 0; m_lo[m][c] = 0; m_trips[m][c] = 0;
      end
  endtask
  // m=0 restarts automatically after cooldown, m=1 waits for a cool restart request
  task automatic model_step(input logic [N-1:0] o, input logic [N-1:0] r);
    for (int m = 0; m < 2; m++)
      for (int c = 0; c < N; c++) begin
        if (m_lock[m][c]) continue;
        if (!m_shut[m][c]) begin
          m_hi[m][c] = o[c] ? m_hi[m][c] + 1 : 0;
          if (m_hi[m][c] == DEB) begin
            m_hi[m][c] = 0; m_trips[m][c]++; m_shut[m][c] = 1; m_done[m][c] = 0; m_lo[m][c] = 0;
            m_lock[m][c] = m_trips[m][c] == MT;
          end
        end else if (!m_done[m][c]) begin
          m_lo[m][c] = o[c] ? 0 : m_lo[m][c] + 1;
          if (m_lo[m][c] == CD) begin
            m_lo[m][c] = 0;
            if (m == 0) m_shut[m][c] = 0; else m_done[m][c] = 1;
          end
        end else if (r[c] && !o[c]) begin
          m_shut[m][c] = 0; m_done[m][c] = 0;
        end else if (o[c] && !r[c]) begin
          m_done[m][c] = 0; m_lo[m][c] = 0;
        end
      end
  endtask
  task automatic check_all(input string tag);
    logic [N-1:0] es[2], el[2];
    for (int m = 0; m < 2; m++)
      for (int c = 0; c < N; c++) begin
        es[m][c] = m_shut[m][c];
        el[m][c] = m_lock[m][c];
      end
    chk({tag, "/shut_a"}, 32'(shut_a), 32'(es[0]));
    chk({tag, "/shut_m"}, 32'(shut_m), 32'(es[1]));
    chk({tag, "/lock_a"}, 32'(lock_a), 32'(el[0]));
    chk({tag, "/lock_m"}, 32'(lock_m), 32'(el[1]));
    chk({tag, "/any_a"}, 32'(any_a), 32'(|es[0]));
    chk({tag, "/any_m"}, 32'(any_m), 32'(|es[1]));
    for (int c = 0; c < N; c++) begin
      chk($sformatf("%s/tc_a%0d", tag, c), 32'(tc_a[c*TW +: TW]), 32'(m_trips[0][c]));
      chk($sformatf("%s/tc_m%0d", tag, c), 32'(tc_m[c*TW +: TW]), 32'(m_trips[1][c]));
    end
  endtask
  task automatic step(input string tag, input logic [N-1:0] o, input logic [N-1:0] r);
    oh = o;
    rr = r;
    @(posedge clk);
    model_step(o, r);
    #1 check_all(tag);
  endtask
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1 model_reset();
    chk({tag, "/now_shut_lock"}, 32'({shut_a, shut_m, lock_a, lock_m}), 32'd0);
    chk({tag, "/now_tc"}, 32'({tc_a, tc_m}), 32'd0);
    chk({tag, "/now_any"}, 32'({any_a, any_m}), 32'd0);
    check_all(tag);
    oh = '0;
    rr = '0;
    @(posedge clk);
    #1 check_all({tag, "/held"});
    rst_n = 1'b1;
  endtask
  initial begin
    logic [N-1:0] lv, rv;
    model_reset();
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 check_all("reset");
    rst_n = 1'b1;
    step("idle", '0, '0);
    repeat (3) step("glitch", 4'b0001, '0);
    step("glitch_low", '0, '0);
    chk("glitch_shut0", 32'(shut_a[0]), 32'd0);
    chk("glitch_tc0", 32'(tc_a[0 +: TW]), 32'd0);
    repeat (3) step("arm1", 4'b0010, '0);
    chk("pre_trip_shut1", 32'(shut_a[1]), 32'd0);
    step("trip1", 4'b0010, '0);
    chk("trip_shut1", 32'(shut_a[1]), 32'd1);
    chk("trip_any", 32'(any_a), 32'd1);
    chk("trip_tc1", 32'(tc_a[TW +: TW]), 32'd1);
    chk("trip_others", 32'({shut_a[3:2], shut_a[0]}), 32'd0);
    repeat (5) step("cool_a", '0, '0);
    step("cool_hot", 4'b0010, '0);
    repeat (7) step("cool_b", '0, '0);
    chk("cool7_shut1", 32'(shut_a[1]), 32'd1);
    step("cool8", '0, '0);
    chk("cool8_auto_shut1", 32'(shut_a[1]), 32'd0);
    chk("cool8_man_shut1", 32'(shut_m[1]), 32'd1);
    step("hold_rr_hot", 4'b0010, 4'b0010);
    chk("hold_rr_hot_shut1", 32'(shut_m[1]), 32'd1);
    step("hold_rr_cool", '0, 4'b0010);
    chk("hold_rr_cool_shut1", 32'(shut_m[1]), 32'd0);
    for (int t = 0; t < 3; t++) begin
      repeat (4) step("trip2", 4'b0100, '0);
      repeat (8) step("cool2", '0, '0);
      step("restart2", '0, 4'b0100);
    end
    chk("lock2_a", 32'(lock_a[2]), 32'd1);
    chk("lock2_m", 32'(lock_m[2]), 32'd1);
    chk("lock2_tc", 32'(tc_a[2*TW +: TW]), 32'd3);
    repeat (10) step("lock2_noise", 4'($urandom_range(0, 15)) & 4'b0100, 4'($urandom_range(0, 15)) & 4'b0100);
    chk("lock2_hold_shut", 32'({shut_a[2], shut_m[2]}), 32'd3);
    chk("lock2_hold_tc", 32'(tc_m[2*TW +: TW]), 32'd3);
    repeat (4) step("trip3", 4'b1000, '0);
    repeat (3) step("cool3", '0, '0);
    chk("cool3_shut3", 32'(shut_a[3]), 32'd1);
    async_reset("async_mid");
    lv = '0;
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, lv[c] ? 4 : 11) == 0) lv[c] = ~lv[c];
        rv[c] = $urandom_range(0, 3) == 0;
      end
      step("rand", lv, rv);
      if (k % 500 == 499) async_reset("rand_rst");
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
